// File: rtl/watch_set_ctrl_pkg.sv
// Shared watch definitions: setting-mode encodings, blink digit positions
// and small helpers used by the time-setting controller.
package watch_set_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    // Bit positions inside blink_mask = {hour10, hour1, min10, min1}
    localparam int DIG_HOUR10 = 3;
    localparam int DIG_HOUR1  = 2;
    localparam int DIG_MIN10  = 1;
    localparam int DIG_MIN1   = 0;

    // MODE key cycles RUN -> SET_HOUR -> SET_MIN -> RUN
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_RUN:      nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: nxt = MODE_SET_MIN;
            default:       nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

    // Blank the digit pair being set on the blink phase; a held INC key keeps all digits lit
    function automatic logic [3:0] blink_mask_f(input mode_e m, input logic phase, input logic inc_held);
        logic [3:0] mask;
        mask = 4'b0000;
        if (inc_held) begin
            mask = 4'b0000;
        end else begin
            case (m)
                MODE_SET_HOUR: begin
                    mask[DIG_HOUR10] = phase;
                    mask[DIG_HOUR1]  = phase;
                end
                MODE_SET_MIN: begin
                    mask[DIG_MIN10] = phase;
                    mask[DIG_MIN1]  = phase;
                end
                default: mask = 4'b0000;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/watch_set_ctrl_key_debounce.sv
// Key conditioner: 2-FF synchroniser, ms-sampled debounce and press-edge
// detection for one active-low raw key. press and held_nx are combinational
// and valid in the accepting tick cycle; the consumer registers its response.
module key_debounce
    #(
        parameter int unsigned DEB_MS = 20
    )
    (
        input  logic clk,
        input  logic rst_n,
        input  logic tick_ms,
        input  logic btn_raw,
        output logic press,
        output logic held_nx
    );

    localparam logic [15:0] DEB_LAST = 16'(DEB_MS - 32'd1);

    logic sync1_r;
    logic sync2_r;
    logic level_r;
    logic [15:0] cnt_r;
    logic accept_s;

    assign accept_s = tick_ms & (sync2_r != level_r) & (cnt_r == DEB_LAST);
    assign press    = accept_s & ~sync2_r;
    // Pressed level as it will be after this edge (level_r is 1 when released)
    assign held_nx  = accept_s ? ~sync2_r : ~level_r;

    // Synchronise the raw key and count consecutive samples that disagree with the debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= 16'd0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (tick_ms) begin
                if (sync2_r != level_r) begin
                    if (cnt_r == DEB_LAST) begin
                        level_r <= sync2_r;
                        cnt_r   <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end else begin
                    cnt_r <= 16'd0;
                end
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller for the digital watch: walks RUN -> SET_HOUR ->
// SET_MIN -> RUN on MODE presses, turns INC presses and auto-repeat into
// single-cycle increment pulses, times out of idle setting and drives the
// digit blink mask. Every output is registered.
module watch_set_ctrl
    import watch_set_ctrl_pkg::*;
    #(
        parameter int unsigned DEB_MS        = 20,
        parameter int unsigned REPEAT_DLY_MS = 500,
        parameter int unsigned REPEAT_MS     = 100,
        parameter int unsigned BLINK_MS      = 250,
        parameter int unsigned TIMEOUT_MS    = 10000
    )
    (
        input  logic       clk,
        input  logic       rst_n,
        input  logic       tick_ms,
        input  logic       btn_mode,
        input  logic       btn_inc,
        output logic [1:0] mode,
        output logic       run_en,
        output logic       inc_hour,
        output logic       inc_min,
        output logic       sec_clr,
        output logic [3:0] blink_mask
    );

    localparam logic [15:0] DLY_LAST = 16'(REPEAT_DLY_MS - 32'd1);
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_MS - 32'd1);
    localparam logic [15:0] BLK_LAST = 16'(BLINK_MS - 32'd1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_MS - 32'd1);

    logic mode_press_s, mode_held_unused_s;
    logic inc_press_s, inc_held_nx_s;

    mode_e       mode_r, mode_nx_s;
    logic [15:0] hold_cnt_r, hold_cnt_nx_s;
    logic        rep_act_r, rep_act_nx_s;
    logic        inc_block_r, inc_block_nx_s;
    logic [15:0] idle_cnt_r, idle_cnt_nx_s;
    logic [15:0] blink_cnt_r, blink_cnt_nx_s;
    logic        phase_r, phase_nx_s;
    logic        rep_hit_s, inc_evt_s, activity_s, mode_chg_s;
    logic        run_en_r, inc_hour_r, inc_min_r, sec_clr_r;
    logic [3:0]  blink_mask_r;

    key_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_ms (tick_ms),
        .btn_raw (btn_mode),
        .press   (mode_press_s),
        .held_nx (mode_held_unused_s)   // only the MODE press edge matters
    );

    key_debounce #(.DEB_MS(DEB_MS)) u_deb_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_ms (tick_ms),
        .btn_raw (btn_inc),
        .press   (inc_press_s),
        .held_nx (inc_held_nx_s)
    );

    // Next-state logic: INC hold/repeat, mode sequencing, idle timeout and blink phase
    always_comb begin
        mode_nx_s      = mode_r;
        hold_cnt_nx_s  = hold_cnt_r;
        rep_act_nx_s   = rep_act_r;
        inc_block_nx_s = inc_block_r;
        idle_cnt_nx_s  = idle_cnt_r;
        blink_cnt_nx_s = blink_cnt_r;
        phase_nx_s     = phase_r;
        rep_hit_s      = 1'b0;
        inc_evt_s      = 1'b0;
        activity_s     = 1'b0;
        mode_chg_s     = 1'b0;

        // A same-tick MODE press blocks INC until the key is released
        if (inc_press_s) begin
            hold_cnt_nx_s = 16'd0;
            rep_act_nx_s  = 1'b0;
            if (mode_press_s) begin
                inc_block_nx_s = 1'b1;
            end else begin
                inc_block_nx_s = inc_block_r;
            end
        end else if (!inc_held_nx_s) begin
            hold_cnt_nx_s  = 16'd0;
            rep_act_nx_s   = 1'b0;
            inc_block_nx_s = 1'b0;
        end else if (tick_ms) begin
            if (rep_act_r) begin
                if (hold_cnt_r == RPT_LAST) begin
                    rep_hit_s     = 1'b1;
                    hold_cnt_nx_s = 16'd0;
                end else begin
                    hold_cnt_nx_s = hold_cnt_r + 16'd1;
                end
            end else begin
                if (hold_cnt_r == DLY_LAST) begin
                    rep_hit_s     = 1'b1;
                    rep_act_nx_s  = 1'b1;
                    hold_cnt_nx_s = 16'd0;
                end else begin
                    hold_cnt_nx_s = hold_cnt_r + 16'd1;
                end
            end
        end else begin
            hold_cnt_nx_s = hold_cnt_r;
        end

        if (!mode_press_s && (mode_r != MODE_RUN) && !inc_block_r && (inc_press_s || rep_hit_s)) begin
            inc_evt_s = 1'b1;
        end else begin
            inc_evt_s = 1'b0;
        end
        activity_s = mode_press_s | inc_press_s | inc_evt_s;

        if (mode_press_s) begin
            mode_nx_s = next_mode(mode_r);
        end else if (tick_ms && (mode_r != MODE_RUN) && !activity_s && (idle_cnt_r == TMO_LAST)) begin
            mode_nx_s = MODE_RUN;
        end else begin
            mode_nx_s = mode_r;
        end
        mode_chg_s = (mode_nx_s != mode_r);

        if (mode_chg_s || activity_s) begin
            idle_cnt_nx_s = 16'd0;
        end else if (tick_ms && (mode_r != MODE_RUN)) begin
            idle_cnt_nx_s = idle_cnt_r + 16'd1;
        end else begin
            idle_cnt_nx_s = idle_cnt_r;
        end

        // A mode change restarts both the blink phase and any auto-repeat in progress
        if (mode_chg_s) begin
            blink_cnt_nx_s = 16'd0;
            phase_nx_s     = 1'b0;
            hold_cnt_nx_s  = 16'd0;
            rep_act_nx_s   = 1'b0;
        end else if (tick_ms) begin
            if (blink_cnt_r == BLK_LAST) begin
                blink_cnt_nx_s = 16'd0;
                phase_nx_s     = ~phase_r;
            end else begin
                blink_cnt_nx_s = blink_cnt_r + 16'd1;
            end
        end else begin
            blink_cnt_nx_s = blink_cnt_r;
        end
    end

    // State and registered outputs; pulses are derived from this cycle's events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r       <= MODE_RUN;
            hold_cnt_r   <= 16'd0;
            rep_act_r    <= 1'b0;
            inc_block_r  <= 1'b0;
            idle_cnt_r   <= 16'd0;
            blink_cnt_r  <= 16'd0;
            phase_r      <= 1'b0;
            run_en_r     <= 1'b1;
            inc_hour_r   <= 1'b0;
            inc_min_r    <= 1'b0;
            sec_clr_r    <= 1'b0;
            blink_mask_r <= 4'b0000;
        end else begin
            mode_r       <= mode_nx_s;
            hold_cnt_r   <= hold_cnt_nx_s;
            rep_act_r    <= rep_act_nx_s;
            inc_block_r  <= inc_block_nx_s;
            idle_cnt_r   <= idle_cnt_nx_s;
            blink_cnt_r  <= blink_cnt_nx_s;
            phase_r      <= phase_nx_s;
            run_en_r     <= (mode_nx_s == MODE_RUN);
            inc_hour_r   <= inc_evt_s & (mode_r == MODE_SET_HOUR);
            inc_min_r    <= inc_evt_s & (mode_r == MODE_SET_MIN);
            sec_clr_r    <= mode_chg_s & (mode_nx_s == MODE_RUN);
            blink_mask_r <= blink_mask_f(mode_nx_s, phase_nx_s, inc_held_nx_s);
        end
    end

    assign mode       = mode_r;
    assign run_en     = run_en_r;
    assign inc_hour   = inc_hour_r;
    assign inc_min    = inc_min_r;
    assign sec_clr    = sec_clr_r;
    assign blink_mask = blink_mask_r;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios followed by
// random key activity, every clock compared with a tick-level reference model.
module tb_watch_set_ctrl;

    localparam int DEB = 2;
    localparam int DLY = 5;
    localparam int REP = 2;
    localparam int BLK = 3;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_ms = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_inc = 1'b1;
    logic [1:0] mode;
    logic       run_en, inc_hour, inc_min, sec_clr;
    logic [3:0] blink_mask;

    always #5 clk = ~clk;

    watch_set_ctrl #(
        .DEB_MS(DEB), .REPEAT_DLY_MS(DLY), .REPEAT_MS(REP), .BLINK_MS(BLK), .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .mode(mode), .run_en(run_en), .inc_hour(inc_hour), .inc_min(inc_min),
        .sec_clr(sec_clr), .blink_mask(blink_mask)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model state, all in ticks
    int m_mode;
    int m_lvl[2];
    int m_prev[2];
    int m_run[2];
    int m_blk, m_t, m_idle, m_bt;
    logic [1:0] e_mode;
    logic       e_run, e_hr, e_mn, e_clr;
    logic [3:0] e_mask;
    int cnt_hr, cnt_mn, cnt_clr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 1; m_prev[k] = 1; m_run[k] = 0;
        end
        m_blk = 0; m_t = 0; m_idle = 0; m_bt = 0;
        e_mode = 2'b00; e_run = 1'b1; e_hr = 1'b0; e_mn = 1'b0; e_clr = 1'b0; e_mask = 4'b0000;
    endtask

    // level follows a sample value once it has been seen DEB ticks in a row
    task automatic deb_sample(input int k, input int s, output int press, output int rel);
        press = 0; rel = 0;
        if (s == m_prev[k]) m_run[k]++; else m_run[k] = 1;
        m_prev[k] = s;
        if (s != m_lvl[k] && m_run[k] >= DEB) begin
            m_lvl[k] = s;
            press = (s == 0) ? 1 : 0;
            rel   = (s == 1) ? 1 : 0;
        end
    endtask

    task automatic model_tick(input int sm, input int si);
        int pm, rm, pi, ri, held, pulse, act, old, ph;
        deb_sample(0, sm, pm, rm);
        deb_sample(1, si, pi, ri);
        old = m_mode;
        pulse = 0;
        held = (m_lvl[1] == 0) ? 1 : 0;
        if (pi != 0) begin
            m_t = 0;
            if (pm != 0) m_blk = 1;
        end else if (held != 0) begin
            m_t++;
        end
        if (ri != 0) m_blk = 0;
        if (pm != 0) begin
            m_mode = (m_mode + 1) % 3;
        end else if (m_mode != 0 && m_blk == 0) begin
            if (pi != 0) pulse = 1;
            else if (held != 0 && m_t >= DLY && ((m_t - DLY) % REP) == 0) pulse = 1;
        end
        act = (pm != 0 || pi != 0 || pulse != 0) ? 1 : 0;
        if (pm == 0 && m_mode != 0 && act == 0) begin
            m_idle++;
            if (m_idle >= TMO) m_mode = 0;
        end
        if (act != 0 || m_mode != old) m_idle = 0;
        if (m_mode != old) begin
            m_bt = 0; m_t = 0;
        end else begin
            m_bt++;
        end
        ph = (m_bt / BLK) % 2;
        e_mode = 2'(m_mode);
        e_run  = (m_mode == 0);
        e_hr   = (pulse != 0 && old == 1);
        e_mn   = (pulse != 0 && old == 2);
        e_clr  = (m_mode != old && m_mode == 0);
        if (held != 0)        e_mask = 4'b0000;
        else if (m_mode == 1) e_mask = (ph != 0) ? 4'b1100 : 4'b0000;
        else if (m_mode == 2) e_mask = (ph != 0) ? 4'b0011 : 4'b0000;
        else                  e_mask = 4'b0000;
    endtask

    task automatic check_outputs();
        check_eq("mode", 32'(mode), 32'(e_mode));
        check_eq("run_en", 32'(run_en), 32'(e_run));
        check_eq("inc_hour", 32'(inc_hour), 32'(e_hr));
        check_eq("inc_min", 32'(inc_min), 32'(e_mn));
        check_eq("sec_clr", 32'(sec_clr), 32'(e_clr));
        check_eq("blink_mask", 32'(blink_mask), 32'(e_mask));
        cnt_hr  += int'(inc_hour);
        cnt_mn  += int'(inc_min);
        cnt_clr += int'(sec_clr);
    endtask

    // one ms: drive raw keys, 4 clocks with tick on the last, check after every edge
    task automatic run_tick(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        for (int k = 0; k < 4; k++) begin
            tick_ms = (k == 3);
            @(posedge clk);
            if (k == 3) begin
                model_tick(int'(m), int'(i));
            end else begin
                e_hr = 1'b0; e_mn = 1'b0; e_clr = 1'b0;
            end
            #1;
            check_outputs();
        end
        tick_ms = 1'b0;
    endtask

    // clean press: selected keys low for DEB ticks, then all released for 3 ticks
    task automatic tap(input logic m, input logic i);
        for (int k = 0; k < 2; k++) run_tick(~m, ~i);
        for (int k = 0; k < 3; k++) run_tick(1'b1, 1'b1);
    endtask

    task automatic zero_counts();
        cnt_hr = 0; cnt_mn = 0; cnt_clr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    initial begin
        logic rm, ri;
        model_reset();
        zero_counts();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_run_en", 32'(run_en), 32'd1);
        check_eq("rst_mask", 32'(blink_mask), 32'd0);
        rst_n = 1'b1;
        repeat (2) run_tick(1'b1, 1'b1);

        // bounce: three 1-tick glitches, then a real press
        for (int g = 0; g < 3; g++) begin
            run_tick(1'b0, 1'b1);
            run_tick(1'b1, 1'b1);
        end
        check_eq("bounce_no_change", 32'(mode), 32'd0);
        tap(1'b1, 1'b0);
        check_eq("bounce_mode", 32'(mode), 32'd1);

        // setting walk: (MODE) INC MODE INC INC MODE
        zero_counts();
        tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        tap(1'b0, 1'b1);
        tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        check_eq("set_inc_hour", 32'(cnt_hr), 32'd1);
        check_eq("set_inc_min", 32'(cnt_mn), 32'd2);
        check_eq("set_sec_clr", 32'(cnt_clr), 32'd1);
        check_eq("set_mode", 32'(mode), 32'd0);

        // auto-repeat in SET_MIN: accept on tick 2, held through +11
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        zero_counts();
        for (int k = 0; k < 13; k++) run_tick(1'b1, 1'b0);
        check_eq("rep_count", 32'(cnt_mn), 32'd5);
        for (int k = 0; k < 3; k++) run_tick(1'b1, 1'b1);
        check_eq("rep_after_release", 32'(cnt_mn), 32'd5);
        tap(1'b1, 1'b0);

        // timeout out of SET_HOUR
        tap(1'b1, 1'b0);
        zero_counts();
        for (int k = 0; k < 22; k++) run_tick(1'b1, 1'b1);
        check_eq("tmo_mode", 32'(mode), 32'd0);
        check_eq("tmo_sec_clr", 32'(cnt_clr), 32'd1);

        // MODE+INC together in SET_HOUR, then INC in RUN
        tap(1'b1, 1'b0);
        zero_counts();
        tap(1'b1, 1'b1);
        check_eq("simul_mode", 32'(mode), 32'd2);
        check_eq("simul_no_inc", 32'(cnt_hr + cnt_mn), 32'd0);
        tap(1'b1, 1'b0);
        zero_counts();
        tap(1'b0, 1'b1);
        check_eq("run_inc_ignored", 32'(cnt_hr + cnt_mn), 32'd0);

        // reset in the middle of SET_MIN
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        check_eq("pre_rst_mode", 32'(mode), 32'd2);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_mode", 32'(mode), 32'd0);
        check_eq("midrst_run_en", 32'(run_en), 32'd1);
        check_eq("midrst_mask", 32'(blink_mask), 32'd0);
        check_eq("midrst_pulses", 32'({inc_hour, inc_min, sec_clr}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        zero_counts();
        for (int k = 0; k < 6; k++) run_tick(1'b1, 1'b1);
        check_eq("post_rst_pulses", 32'(cnt_hr + cnt_mn + cnt_clr), 32'd0);

        // random key activity with persistent levels
        rm = 1'b1;
        ri = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 5) == 0) rm = ~rm;
            if ($urandom_range(0, 3) == 0) ri = ~ri;
            run_tick(rm, ri);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
